// File: rtl/rename_map_pkg.sv
// Package for the rename slice: default widths and register-index constants.
// Optional busy table is enabled with RENAME_BUSY_TABLE_EN (see rename_map.sv).
package rename_map_pkg;
`include "rename_defs.vh"
endpackage

// File: rtl/map_table.sv
// Architectural-to-physical map: identity reset, two async reads, one write,
// and a bulk load that overwrites every entry (used for flush recovery).
module map_table
    import rename_map_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int PWIDTH = DEF_PWIDTH,
    localparam int NREGS = 2**AWIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [AWIDTH-1:0]       i_waddr,
    input  logic [PWIDTH-1:0]       i_wdata,
    input  logic                    i_load,
    input  logic [NREGS*PWIDTH-1:0] i_load_data,
    input  logic [AWIDTH-1:0]       i_raddr1,
    input  logic [AWIDTH-1:0]       i_raddr2,
    output logic [PWIDTH-1:0]       o_rdata1,
    output logic [PWIDTH-1:0]       o_rdata2,
    output logic [NREGS*PWIDTH-1:0] o_contents
);

    localparam logic [AWIDTH-1:0] X0 = AWIDTH'(ZERO_REG);

    logic [PWIDTH-1:0] map [NREGS];

    // Load wins over the single write; x0 is never written so it stays 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                map[i] <= PWIDTH'(i);
            end
        end else if (i_load) begin
            for (int i = 0; i < NREGS; i++) begin
                map[i] <= i_load_data[i*PWIDTH +: PWIDTH];
            end
        end else if (i_we && (i_waddr != X0)) begin
            map[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == X0) ? '0 : map[i_raddr1];
    assign o_rdata2 = (i_raddr2 == X0) ? '0 : map[i_raddr2];

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign o_contents[g*PWIDTH +: PWIDTH] = map[g];
    end

endmodule

// File: rtl/rename_defs.vh
// Shared rename-stage constants, textually included into rename_map_pkg.
// FREE_BASE is the first physical register owned by the freelist (its STNUM).
localparam int DEF_AWIDTH = 5;
localparam int DEF_PWIDTH = 6;
localparam int ZERO_REG   = 0;
localparam int FREE_BASE  = 2**DEF_AWIDTH;

// File: rtl/rename_map.sv
// Register alias table: one rename per cycle, speculative + committed maps.
// Define RENAME_BUSY_TABLE_EN to add the physical-register busy table and ready outputs.
module rename_map
    import rename_map_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int PWIDTH = DEF_PWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [AWIDTH-1:0] i_rs1,
    input  logic [AWIDTH-1:0] i_rs2,
    input  logic [AWIDTH-1:0] i_rd,
    input  logic              i_rd_we,
    input  logic              i_stall,
    input  logic [PWIDTH-1:0] i_fl_data,
    input  logic              i_fl_empty,
    output logic              o_fl_re,
    output logic              o_valid,
    output logic [PWIDTH-1:0] o_prs1,
    output logic [PWIDTH-1:0] o_prs2,
    output logic [PWIDTH-1:0] o_prd,
    output logic [PWIDTH-1:0] o_prd_old,
    input  logic              i_cmt_valid,
    input  logic [AWIDTH-1:0] i_cmt_rd,
    input  logic [PWIDTH-1:0] i_cmt_prd,
    input  logic [PWIDTH-1:0] i_cmt_prd_old,
    output logic              o_free_we,
    output logic [PWIDTH-1:0] o_free_data,
    input  logic              i_flush
`ifdef RENAME_BUSY_TABLE_EN
    ,
    input  logic              i_wb_valid,
    input  logic [PWIDTH-1:0] i_wb_prd,
    output logic              o_prs1_rdy,
    output logic              o_prs2_rdy
`endif
);

    localparam int NREGS = 2**AWIDTH;
    localparam logic [AWIDTH-1:0] X0 = AWIDTH'(ZERO_REG);

    logic                    alloc;
    logic                    fire;
    logic                    cmt_we;
    logic [PWIDTH-1:0]       spec_rs1;
    logic [PWIDTH-1:0]       spec_rs2;
    logic [PWIDTH-1:0]       spec_rd_old;
    logic [NREGS*PWIDTH-1:0] spec_contents;
    logic [NREGS*PWIDTH-1:0] cmt_contents;
    logic [NREGS*PWIDTH-1:0] flush_image;
    logic [PWIDTH-1:0]       cmt_rd1_unused;
    logic [PWIDTH-1:0]       cmt_rd2_unused;

    assign alloc       = i_rd_we && (i_rd != X0);
    assign o_ready     = !i_flush && !i_stall && !(alloc && i_fl_empty);
    assign fire        = i_valid && o_ready && !i_rst;
    assign o_fl_re     = fire && alloc;
    assign cmt_we      = i_cmt_valid && (i_cmt_rd != X0);
    assign o_free_we   = i_cmt_valid && (i_cmt_prd_old != '0) && !i_rst;
    assign o_free_data = i_cmt_prd_old;
    assign spec_rd_old = spec_contents[int'(i_rd)*PWIDTH +: PWIDTH];

    // Flush restores from the committed map with this cycle's commit written through.
    always_comb begin
        flush_image = cmt_contents;
        if (cmt_we) begin
            flush_image[int'(i_cmt_rd)*PWIDTH +: PWIDTH] = i_cmt_prd;
        end
    end

    map_table #(.AWIDTH(AWIDTH), .PWIDTH(PWIDTH)) u_spec (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (fire && alloc),
        .i_waddr     (i_rd),
        .i_wdata     (i_fl_data),
        .i_load      (i_flush),
        .i_load_data (flush_image),
        .i_raddr1    (i_rs1),
        .i_raddr2    (i_rs2),
        .o_rdata1    (spec_rs1),
        .o_rdata2    (spec_rs2),
        .o_contents  (spec_contents)
    );

    map_table #(.AWIDTH(AWIDTH), .PWIDTH(PWIDTH)) u_cmt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (cmt_we),
        .i_waddr     (i_cmt_rd),
        .i_wdata     (i_cmt_prd),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_raddr1    (X0),
        .i_raddr2    (X0),
        .o_rdata1    (cmt_rd1_unused),
        .o_rdata2    (cmt_rd2_unused),
        .o_contents  (cmt_contents)
    );

    // Renamed instruction register; data fields are only meaningful when o_valid is set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_prs1    <= '0;
            o_prs2    <= '0;
            o_prd     <= '0;
            o_prd_old <= '0;
        end else begin
            o_valid   <= fire;
            o_prs1    <= spec_rs1;
            o_prs2    <= spec_rs2;
            o_prd     <= alloc ? i_fl_data : '0;
            o_prd_old <= alloc ? spec_rd_old : '0;
        end
    end

`ifdef RENAME_BUSY_TABLE_EN
    logic [2**PWIDTH-1:0] busy;

    // A same-cycle allocation of the preg being written back leaves it busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy <= '0;
        end else if (i_flush) begin
            busy <= '0;
        end else begin
            if (i_wb_valid) begin
                busy[i_wb_prd] <= 1'b0;
            end
            if (fire && alloc) begin
                busy[i_fl_data] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_prs1_rdy <= 1'b1;
            o_prs2_rdy <= 1'b1;
        end else begin
            o_prs1_rdy <= (spec_rs1 == '0) || !busy[spec_rs1] || (i_wb_valid && (i_wb_prd == spec_rs1));
            o_prs2_rdy <= (spec_rs2 == '0) || !busy[spec_rs2] || (i_wb_valid && (i_wb_prd == spec_rs2));
        end
    end
`endif

endmodule

// File: tb/tb_rename_map.sv
// Testbench for rename_map: directed test-plan steps, then random traffic against
// an array-based alias-table model. Busy-table checks follow RENAME_BUSY_TABLE_EN.
module tb_rename_map;
    import rename_map_pkg::*;

    localparam int AW = DEF_AWIDTH;
    localparam int PW = DEF_PWIDTH;
    localparam int NA = 2**AW;
    localparam int NP = 2**PW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [AW-1:0] i_rs1, i_rs2, i_rd;
    logic          i_rd_we;
    logic          i_stall;
    logic [PW-1:0] i_fl_data;
    logic          i_fl_empty;
    logic          o_fl_re;
    logic          o_valid;
    logic [PW-1:0] o_prs1, o_prs2, o_prd, o_prd_old;
    logic          i_cmt_valid;
    logic [AW-1:0] i_cmt_rd;
    logic [PW-1:0] i_cmt_prd, i_cmt_prd_old;
    logic          o_free_we;
    logic [PW-1:0] o_free_data;
    logic          i_flush;
`ifdef RENAME_BUSY_TABLE_EN
    logic          i_wb_valid;
    logic [PW-1:0] i_wb_prd;
    logic          o_prs1_rdy, o_prs2_rdy;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int spec_m [NA];
    int cmt_m  [NA];
    bit busy_m [NP];

    rename_map dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_rd          (i_rd),
        .i_rd_we       (i_rd_we),
        .i_stall       (i_stall),
        .i_fl_data     (i_fl_data),
        .i_fl_empty    (i_fl_empty),
        .o_fl_re       (o_fl_re),
        .o_valid       (o_valid),
        .o_prs1        (o_prs1),
        .o_prs2        (o_prs2),
        .o_prd         (o_prd),
        .o_prd_old     (o_prd_old),
        .i_cmt_valid   (i_cmt_valid),
        .i_cmt_rd      (i_cmt_rd),
        .i_cmt_prd     (i_cmt_prd),
        .i_cmt_prd_old (i_cmt_prd_old),
        .o_free_we     (o_free_we),
        .o_free_data   (o_free_data),
        .i_flush       (i_flush)
`ifdef RENAME_BUSY_TABLE_EN
        ,
        .i_wb_valid    (i_wb_valid),
        .i_wb_prd      (i_wb_prd),
        .o_prs1_rdy    (o_prs1_rdy),
        .o_prs2_rdy    (o_prs2_rdy)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < NA; i++) begin
            spec_m[i] = i;
            cmt_m[i]  = i;
        end
        for (int i = 0; i < NP; i++) busy_m[i] = 1'b0;
    endtask

    task automatic idleInputs();
        i_valid = 1'b0; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_rd_we = 1'b0;
        i_stall = 1'b0; i_fl_data = '0; i_fl_empty = 1'b0;
        i_cmt_valid = 1'b0; i_cmt_rd = '0; i_cmt_prd = '0; i_cmt_prd_old = '0;
        i_flush = 1'b0;
`ifdef RENAME_BUSY_TABLE_EN
        i_wb_valid = 1'b0; i_wb_prd = '0;
`endif
    endtask

    // Drive a rename request at the falling edge; everything else returns to idle.
    task automatic applyStimulus(input bit valid, input int rs1, input int rs2,
                                 input int rd, input bit rd_we, input int fl_data);
        @(negedge i_clk);
        idleInputs();
        i_valid   = valid;
        i_rs1     = AW'(rs1);
        i_rs2     = AW'(rs2);
        i_rd      = AW'(rd);
        i_rd_we   = rd_we;
        i_fl_data = PW'(fl_data);
    endtask

    // Check same-cycle outputs, advance one clock, check the registered outputs.
    task automatic runCycle(input string tag);
        bit alloc, rdy, fire, free_we;
        int e_prs1, e_prs2, e_prd, e_old;
        bit e_r1, e_r2;
        #1;
        alloc   = i_rd_we && (i_rd != 0);
        rdy     = !i_flush && !i_stall && !(alloc && i_fl_empty);
        fire    = i_valid && rdy;
        free_we = i_cmt_valid && (i_cmt_prd_old != 0);
        checkOutput({tag, "_ready"}, 32'(o_ready), 32'(rdy));
        checkOutput({tag, "_fl_re"}, 32'(o_fl_re), 32'(fire && alloc));
        checkOutput({tag, "_free_we"}, 32'(o_free_we), 32'(free_we));
        if (free_we) checkOutput({tag, "_free_data"}, 32'(o_free_data), 32'(i_cmt_prd_old));

        e_prs1 = (i_rs1 == 0) ? 0 : spec_m[i_rs1];
        e_prs2 = (i_rs2 == 0) ? 0 : spec_m[i_rs2];
        e_prd  = alloc ? int'(i_fl_data) : 0;
        e_old  = alloc ? spec_m[i_rd] : 0;
        e_r1   = 1'b1;
        e_r2   = 1'b1;
`ifdef RENAME_BUSY_TABLE_EN
        e_r1 = (e_prs1 == 0) || !busy_m[e_prs1] || (i_wb_valid && int'(i_wb_prd) == e_prs1);
        e_r2 = (e_prs2 == 0) || !busy_m[e_prs2] || (i_wb_valid && int'(i_wb_prd) == e_prs2);
        if (i_flush) begin
            for (int i = 0; i < NP; i++) busy_m[i] = 1'b0;
        end else begin
            if (i_wb_valid) busy_m[i_wb_prd] = 1'b0;
            if (fire && alloc) busy_m[i_fl_data] = 1'b1;
        end
`endif
        if (i_cmt_valid && i_cmt_rd != 0) cmt_m[i_cmt_rd] = int'(i_cmt_prd);
        if (i_flush) spec_m = cmt_m;
        else if (fire && alloc) spec_m[i_rd] = int'(i_fl_data);

        @(posedge i_clk);
        #1;
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'(fire));
        checkOutput({tag, "_prs1"}, 32'(o_prs1), 32'(e_prs1));
        checkOutput({tag, "_prs2"}, 32'(o_prs2), 32'(e_prs2));
        checkOutput({tag, "_prd"}, 32'(o_prd), 32'(e_prd));
        checkOutput({tag, "_prd_old"}, 32'(o_prd_old), 32'(e_old));
`ifdef RENAME_BUSY_TABLE_EN
        checkOutput({tag, "_rdy1"}, 32'(o_prs1_rdy), 32'(e_r1));
        checkOutput({tag, "_rdy2"}, 32'(o_prs2_rdy), 32'(e_r2));
`else
        if (e_r1 != e_r2) $display("[TB] note: ready model diverged");
`endif
    endtask

    initial begin
        idleInputs();
        resetModel();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_prs1", 32'(o_prs1), 32'd0);
        checkOutput("rst_prd", 32'(o_prd), 32'd0);
        checkOutput("rst_prd_old", 32'(o_prd_old), 32'd0);
        checkOutput("rst_fl_re", 32'(o_fl_re), 32'd0);
        checkOutput("rst_free_we", 32'(o_free_we), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // First rename from identity map
        applyStimulus(1, 3, 4, 5, 1, 32);
        runCycle("t1");
        checkOutput("t1_prs1_c", 32'(o_prs1), 32'd3);
        checkOutput("t1_prs2_c", 32'(o_prs2), 32'd4);
        checkOutput("t1_prd_c", 32'(o_prd), 32'd32);
        checkOutput("t1_old_c", 32'(o_prd_old), 32'd5);

        // Back-to-back renames of rd=5, then a dependent read
        applyStimulus(1, 0, 0, 5, 1, 33);
        runCycle("t2");
        checkOutput("t2_old_c", 32'(o_prd_old), 32'd32);
        applyStimulus(1, 5, 0, 0, 0, 0);
        runCycle("t3");
        checkOutput("t3_prs1_c", 32'(o_prs1), 32'd33);

        // rd = x0 never allocates
        applyStimulus(1, 0, 0, 0, 1, 34);
        runCycle("t4");
        checkOutput("t4_prd_c", 32'(o_prd), 32'd0);
        checkOutput("t4_old_c", 32'(o_prd_old), 32'd0);

        // Empty freelist blocks only allocating renames
        applyStimulus(1, 1, 2, 6, 1, 35);
        i_fl_empty = 1'b1;
        runCycle("t5a");
        checkOutput("t5a_valid_c", 32'(o_valid), 32'd0);
        applyStimulus(1, 6, 0, 0, 0, 0);
        runCycle("t5b");
        checkOutput("t5b_prs1_c", 32'(o_prs1), 32'd6);
        applyStimulus(1, 1, 0, 0, 0, 0);
        i_fl_empty = 1'b1;
        runCycle("t5c");
        checkOutput("t5c_valid_c", 32'(o_valid), 32'd1);

        // Commit, speculative rename, then flush with a same-cycle commit
        applyStimulus(1, 0, 0, 7, 1, 40);
        runCycle("t6a");
        applyStimulus(0, 0, 0, 0, 0, 0);
        i_cmt_valid = 1'b1; i_cmt_rd = 5'd7; i_cmt_prd = 6'd40; i_cmt_prd_old = 6'd7;
        runCycle("t6b");
        checkOutput("t6b_free_data_c", 32'(o_free_data), 32'd7);
        applyStimulus(1, 0, 0, 7, 1, 41);
        runCycle("t6c");
        applyStimulus(1, 0, 0, 7, 1, 42);
        i_flush = 1'b1;
        i_cmt_valid = 1'b1; i_cmt_rd = 5'd8; i_cmt_prd = 6'd50; i_cmt_prd_old = 6'd8;
        runCycle("t6d");
        checkOutput("t6d_valid_c", 32'(o_valid), 32'd0);
        applyStimulus(1, 7, 8, 0, 0, 0);
        runCycle("t6e");
        checkOutput("t6e_prs1_c", 32'(o_prs1), 32'd40);
        checkOutput("t6e_prs2_c", 32'(o_prs2), 32'd50);

        // Commit freeing preg 0 is suppressed
        applyStimulus(0, 0, 0, 0, 0, 0);
        i_cmt_valid = 1'b1; i_cmt_rd = 5'd3; i_cmt_prd = 6'd36; i_cmt_prd_old = 6'd0;
        runCycle("t7");
        checkOutput("t7_free_we_c", 32'(o_free_we), 32'd0);

        // Rename and commit to the same arch reg land in separate tables
        applyStimulus(1, 0, 0, 9, 1, 45);
        i_cmt_valid = 1'b1; i_cmt_rd = 5'd9; i_cmt_prd = 6'd44; i_cmt_prd_old = 6'd9;
        runCycle("t8a");
        applyStimulus(1, 9, 0, 0, 0, 0);
        runCycle("t8b");
        checkOutput("t8b_prs1_c", 32'(o_prs1), 32'd45);
        applyStimulus(0, 0, 0, 0, 0, 0);
        i_flush = 1'b1;
        runCycle("t8c");
        applyStimulus(1, 9, 3, 0, 0, 0);
        runCycle("t8d");
        checkOutput("t8d_prs1_c", 32'(o_prs1), 32'd44);
        checkOutput("t8d_prs2_c", 32'(o_prs2), 32'd36);

`ifdef RENAME_BUSY_TABLE_EN
        applyStimulus(1, 0, 0, 9, 1, 52);
        runCycle("t9a");
        applyStimulus(1, 9, 0, 0, 0, 0);
        runCycle("t9b");
        checkOutput("t9b_rdy_c", 32'(o_prs1_rdy), 32'd0);
        applyStimulus(1, 9, 0, 0, 0, 0);
        i_wb_valid = 1'b1; i_wb_prd = 6'd52;
        runCycle("t9c");
        checkOutput("t9c_rdy_c", 32'(o_prs1_rdy), 32'd1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, NA-1)),
                          int'($urandom_range(0, NA-1)), int'($urandom_range(0, NA-1)),
                          $urandom_range(0, 4) != 0, int'($urandom_range(FREE_BASE, NP-1)));
            i_stall       = ($urandom_range(0, 9) == 0);
            i_fl_empty    = ($urandom_range(0, 9) == 0);
            i_cmt_valid   = ($urandom_range(0, 2) == 0);
            i_cmt_rd      = AW'($urandom_range(0, NA-1));
            i_cmt_prd     = PW'($urandom_range(FREE_BASE, NP-1));
            i_cmt_prd_old = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, NP-1));
            i_flush       = ($urandom_range(0, 19) == 0);
`ifdef RENAME_BUSY_TABLE_EN
            i_wb_valid    = ($urandom_range(0, 2) == 0);
            i_wb_prd      = PW'($urandom_range(FREE_BASE, NP-1));
`endif
            runCycle("rand");
        end

        // Asynchronous reset in the middle of a valid output
        applyStimulus(1, 0, 0, 6, 1, 55);
        runCycle("r1");
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(o_valid), 32'd0);
        checkOutput("arst_prd", 32'(o_prd), 32'd0);
        resetModel();
        @(negedge i_clk);
        idleInputs();
        i_rst = 1'b0;
        applyStimulus(1, 6, 5, 0, 0, 0);
        runCycle("r2");
        checkOutput("r2_prs1_c", 32'(o_prs1), 32'd6);
        checkOutput("r2_prs2_c", 32'(o_prs2), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- Register alias table for the rename stage. It sits directly downstream of the physical-register freelist.
- Each cycle it renames up to one instruction. It maps rs1/rs2 to physical registers, pops one free physical register for rd, and records the previous mapping so the ROB can free it.
- Holds a speculative map and a committed map. On flush, the speculative map is restored from the committed map.
- Drives the freelist write port at commit, returning old physical registers.

Parameters:
- AWIDTH, 5, architectural register index width (2**AWIDTH arch regs).
- PWIDTH, 6, physical register index width; freelist holds pregs 2**AWIDTH .. 2**PWIDTH-1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  rename request
- o_ready  out  1  request accepted this cycle
- i_rs1, i_rs2  in  AWIDTH  source arch regs
- i_rd  in  AWIDTH  destination arch reg
- i_rd_we  in  1  instruction writes rd
- i_stall  in  1  downstream (ROB/issue) cannot accept
- i_fl_data  in  PWIDTH  head entry of freelist
- i_fl_empty  in  1  freelist has no free entry
- o_fl_re  out  1  pop freelist
- o_valid  out  1  registered renamed-instruction valid
- o_prs1, o_prs2  out  PWIDTH  renamed sources
- o_prd  out  PWIDTH  allocated destination preg (0 if no rd)
- o_prd_old  out  PWIDTH  previous mapping of rd (to ROB)
- i_cmt_valid  in  1  ROB commit of one instruction with rd
- i_cmt_rd  in  AWIDTH  committed arch reg
- i_cmt_prd  in  PWIDTH  committed new preg
- i_cmt_prd_old  in  PWIDTH  preg to free
- o_free_we  out  1  freelist push
- o_free_data  out  PWIDTH  preg pushed to freelist
- i_flush  in  1  mispredict/exception recovery

Behaviour:
- Clock/reset: one clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset state:
  - Both maps set to map[i]=i.
  - o_valid=0; o_prs1, o_prs2, o_prd and o_prd_old are 0.
  - o_fl_re=0, o_free_we=0.
- Allocation needed: alloc = i_rd_we && i_rd!=0.
- Ready (combinational): o_ready = !i_flush && !i_stall && !(alloc && i_fl_empty).
- Fire: fire = i_valid && o_ready. o_fl_re = fire && alloc, combinational, same cycle.
- Output register, updated on posedge with 1-cycle latency:
  - o_valid <= fire.
  - o_prs1/o_prs2 <= spec map read of i_rs1/i_rs2 (x0 always reads 0).
  - o_prd <= alloc ? i_fl_data : 0.
  - o_prd_old <= alloc ? spec[i_rd] : 0.
- Speculative map: on fire && alloc, spec[i_rd] <= i_fl_data.
  - Back-to-back dependent renames need no bypass, because the write lands before the next read.
- x0 is never renamed and never written in either map.
- Commit:
  - On i_cmt_valid && i_cmt_rd!=0: committed[i_cmt_rd] <= i_cmt_prd.
  - On i_cmt_valid: o_free_we=1 and o_free_data=i_cmt_prd_old, combinational, same cycle. Suppressed when i_cmt_prd_old==0.
- Flush:
  - i_flush has priority over rename. No fire and no pop that cycle; o_valid <= 0.
  - Spec map <= committed map, including a same-cycle commit (write-through: spec[i_cmt_rd] gets i_cmt_prd).
  - Freelist head recovery is outside this block.
- Simultaneous commit and rename to the same arch reg: independent tables, both writes take effect.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight o_valid is dropped.

Optional Feature:
- Macro: RENAME_BUSY_TABLE_EN.
- When defined:
  - Adds a 2**PWIDTH busy-bit vector.
  - Adds ports i_wb_valid (1), i_wb_prd (PWIDTH), o_prs1_rdy (1), o_prs2_rdy (1).
  - On fire && alloc, busy[i_fl_data] <= 1. On i_wb_valid, busy[i_wb_prd] <= 0.
  - o_prsN_rdy <= !busy[prsN] || (i_wb_valid && i_wb_prd==prsN). Preg 0 is always ready.
  - Flush clears all busy bits; reset clears all.
- When undefined: none of these ports or state exist.

Decomposition:
- Shared include file rename_defs.vh holds:
  - Default AWIDTH/PWIDTH.
  - Constant ZERO_REG=0.
  - FREE_BASE=2**AWIDTH, which is also the freelist STNUM.
- One natural sub-module, map_table: 2**AWIDTH x PWIDTH array with identity reset, 2 async read ports, 1 write port, and a bulk-load input.
  - Instantiated twice: spec and committed.
  - The committed instance exposes its full contents for the load.

Test Plan:
- Reset, then rename rs1=3, rs2=4, rd=5, i_fl_data=32 -> next cycle o_prs1=3, o_prs2=4, o_prd=32, o_prd_old=5, o_valid=1; o_fl_re pulses 1 cycle.
- Back-to-back rd=5 with fl_data 32 then 33, then read rs1=5 -> o_prd_old=32 on the second rename, o_prs1=33 on the third.
- i_rd=0 with i_rd_we=1 -> o_fl_re=0, o_prd=0, o_prd_old=0.
- i_fl_empty=1 with alloc -> o_ready=0, no map change. i_fl_empty=1 with i_rd_we=0 -> accepted.
- Rename rd=7 to 40, commit (rd=7, prd=40, prd_old=7) -> o_free_we=1, o_free_data=7. Rename rd=7 to 41, then flush -> next read of rs1=7 gives 40.
- With RENAME_BUSY_TABLE_EN: allocate 42 to rd=9, read rs1=9 -> rdy=0. Then i_wb_prd=42 in the same cycle as a read -> rdy=1.
